// File: rtl/masked_3stage_rand_sched_pkg.sv
// rtl/masked_3stage_rand_sched_pkg.sv - HPC3 randomness budget per inverter stage
package aes128_package;

    // Independent share pairs; HPC3 draws a fixed number of fresh bits per pair and stage.
    function automatic int hpc3_pairs(input int num_shares);
        return num_shares * (num_shares - 1) / 2;
    endfunction

    function automatic int stage_1_hpc3_randoms(input int num_shares);
        return 8 * hpc3_pairs(num_shares);
    endfunction

    function automatic int stage_2_hpc3_randoms(input int num_shares);
        return 4 * hpc3_pairs(num_shares);
    endfunction

    function automatic int stage_3_hpc3_randoms(input int num_shares);
        return 16 * hpc3_pairs(num_shares);
    endfunction

    function automatic int rand_total(input int num_shares);
        return stage_1_hpc3_randoms(num_shares) + stage_2_hpc3_randoms(num_shares)
             + stage_3_hpc3_randoms(num_shares);
    endfunction

endpackage

// File: rtl/masked_3stage_rand_sched_fifo.sv
// rtl/masked_3stage_rand_sched_fifo.sv - synchronous random-word FIFO with level and flush
module masked_rand_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     wr_valid_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    output logic                     wr_ready_o,
    input  logic                     rd_en_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_LVL  = (AW+1)'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             wr_fire, rd_fire;

    assign rd_fire    = rd_en_i && (level_q != '0) && !flush_i;
    // A pop frees the head slot this cycle, so a full FIFO can still take a word.
    assign wr_ready_o = (level_q != FULL_LVL) || rd_fire;
    assign wr_fire    = wr_valid_i && wr_ready_o && !flush_i;
    assign rd_data_o  = mem_q[rd_ptr_q];
    assign level_o    = level_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (wr_fire) wr_ptr_d = wr_ptr_q + 1'b1;
            if (rd_fire) rd_ptr_d = rd_ptr_q + 1'b1;
            if (wr_fire && !rd_fire) level_d = level_q + ONE_LVL;
            if (!wr_fire && rd_fire) level_d = level_q - ONE_LVL;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_fire) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/masked_3stage_rand_sched.sv
// rtl/masked_3stage_rand_sched.sv - random-word scheduler for 3-stage HPC3 inverter (opt. MASKED_RAND_SCHED_CNT_EN)
module masked_3stage_rand_sched
    import aes128_package::*;
#(
    parameter int NUM_SHARES = 2,
    parameter int FIFO_DEPTH = 4,
    localparam int R1 = stage_1_hpc3_randoms(NUM_SHARES),
    localparam int R2 = stage_2_hpc3_randoms(NUM_SHARES),
    localparam int R3 = stage_3_hpc3_randoms(NUM_SHARES),
    localparam int RAND_TOTAL = R1 + R2 + R3,
    localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  in_clock,
    input  logic                  in_reset,
    input  logic [RAND_TOTAL-1:0] in_rand,
    input  logic                  in_rand_valid,
    output logic                  out_rand_ready,
    input  logic                  in_flush,
    input  logic                  in_op_valid,
    output logic                  out_op_ready,
    output logic [2:0]            out_stage_en,
    output logic [R1-1:0]         out_random_s1,
    output logic [R2-1:0]         out_random_s2,
    output logic [R3-1:0]         out_random_s3,
    output logic                  out_result_valid,
`ifdef MASKED_RAND_SCHED_CNT_EN
    output logic [31:0]           out_op_count,
    output logic [31:0]           out_starve_count,
`endif
    output logic [LW-1:0]         out_fifo_level
);
    logic [RAND_TOTAL-1:0] head;
    logic                  admit;
    logic [1:0]            v_q, v_d;
    logic                  res_q, res_d;
    logic [R1-1:0]         s1_q, s1_d;
    logic [R2-1:0]         s2_q, s2_d;
    logic [R3-1:0]         s3_pipe_q, s3_pipe_d, s3_q, s3_d;

    masked_rand_fifo #(.WIDTH(RAND_TOTAL), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i      (in_clock),
        .rst_i      (in_reset),
        .flush_i    (in_flush),
        .wr_valid_i (in_rand_valid),
        .wr_data_i  (in_rand),
        .wr_ready_o (out_rand_ready),
        .rd_en_i    (admit),
        .rd_data_o  (head),
        .level_o    (out_fifo_level)
    );

    assign out_op_ready     = (out_fifo_level != '0) && !in_flush;
    assign admit            = in_op_valid && out_op_ready;
    assign out_stage_en     = {v_q, admit};
    assign out_result_valid = res_q;
    // Stage 1 consumes its slice in the admit cycle, straight off the FIFO head.
    assign out_random_s1    = admit ? head[R1-1:0] : s1_q;
    assign out_random_s2    = s2_q;
    assign out_random_s3    = s3_q;

    always_comb begin
        v_d       = {v_q[0], admit};
        res_d     = v_q[1];
        s1_d      = admit ? head[R1-1:0] : s1_q;
        s2_d      = admit ? head[R1+R2-1:R1] : s2_q;
        s3_pipe_d = admit ? head[RAND_TOTAL-1:R1+R2] : s3_pipe_q;
        s3_d      = v_q[0] ? s3_pipe_q : s3_q;
    end

    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            v_q       <= '0;
            res_q     <= 1'b0;
            s1_q      <= '0;
            s2_q      <= '0;
            s3_pipe_q <= '0;
            s3_q      <= '0;
        end else begin
            v_q       <= v_d;
            res_q     <= res_d;
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            s3_pipe_q <= s3_pipe_d;
            s3_q      <= s3_d;
        end
    end

`ifdef MASKED_RAND_SCHED_CNT_EN
    logic [31:0] op_cnt_q, op_cnt_d, starve_cnt_q, starve_cnt_d;

    always_comb begin
        op_cnt_d     = op_cnt_q;
        starve_cnt_d = starve_cnt_q;
        if (in_flush) begin
            op_cnt_d     = '0;
            starve_cnt_d = '0;
        end else begin
            if (admit && (op_cnt_q != '1)) op_cnt_d = op_cnt_q + 32'd1;
            if (in_op_valid && !out_op_ready && (starve_cnt_q != '1))
                starve_cnt_d = starve_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            op_cnt_q     <= '0;
            starve_cnt_q <= '0;
        end else begin
            op_cnt_q     <= op_cnt_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign out_op_count     = op_cnt_q;
    assign out_starve_count = starve_cnt_q;
`endif

endmodule

// File: tb/tb_masked_3stage_rand_sched.sv
// tb/tb_masked_3stage_rand_sched.sv - scoreboard bench for masked_3stage_rand_sched
module tb_masked_3stage_rand_sched;
    import aes128_package::*;

    localparam int NS    = 2;
    localparam int DEPTH = 4;
    localparam int R1 = stage_1_hpc3_randoms(NS);
    localparam int R2 = stage_2_hpc3_randoms(NS);
    localparam int R3 = stage_3_hpc3_randoms(NS);
    localparam int RT = R1 + R2 + R3;
    localparam int LW = $clog2(DEPTH) + 1;

    logic          in_clock = 1'b0;
    logic          in_reset = 1'b1;
    logic [RT-1:0] in_rand = '0;
    logic          in_rand_valid = 1'b0;
    logic          out_rand_ready;
    logic          in_flush = 1'b0;
    logic          in_op_valid = 1'b0;
    logic          out_op_ready;
    logic [2:0]    out_stage_en;
    logic [R1-1:0] out_random_s1;
    logic [R2-1:0] out_random_s2;
    logic [R3-1:0] out_random_s3;
    logic          out_result_valid;
    logic [LW-1:0] out_fifo_level;
`ifdef MASKED_RAND_SCHED_CNT_EN
    logic [31:0]   out_op_count, out_starve_count;
`endif

    masked_3stage_rand_sched #(.NUM_SHARES(NS), .FIFO_DEPTH(DEPTH)) dut (
        .in_clock         (in_clock),
        .in_reset         (in_reset),
        .in_rand          (in_rand),
        .in_rand_valid    (in_rand_valid),
        .out_rand_ready   (out_rand_ready),
        .in_flush         (in_flush),
        .in_op_valid      (in_op_valid),
        .out_op_ready     (out_op_ready),
        .out_stage_en     (out_stage_en),
        .out_random_s1    (out_random_s1),
        .out_random_s2    (out_random_s2),
        .out_random_s3    (out_random_s3),
        .out_result_valid (out_result_valid),
`ifdef MASKED_RAND_SCHED_CNT_EN
        .out_op_count     (out_op_count),
        .out_starve_count (out_starve_count),
`endif
        .out_fifo_level   (out_fifo_level)
    );

    always #5 in_clock = ~in_clock;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int res_seen = 0;

    // Reference state: buffered words, words waiting for stage 2/3, result due cycles.
    logic [RT-1:0] mf[$];
    logic [RT-1:0] s2q[$];
    logic [RT-1:0] s3q[$];
    int            resq[$];
    logic          v1m = 1'b0, v2m = 1'b0;
    logic [R1-1:0] last_s1 = '0;
    logic [R2-1:0] last_s2 = '0;
    logic [R3-1:0] last_s3 = '0;
    int            opc = 0, stc = 0;

    logic          obs_rdy, obs_opr, obs_res;
    logic [2:0]    obs_en;
    logic [LW-1:0] obs_level;
    logic [R1-1:0] obs_s1;
    logic [R2-1:0] obs_s2;
    logic [R3-1:0] obs_s3;
    logic [31:0]   obs_stc;

    function automatic logic [RT-1:0] rnd_word();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[RT-1:0];
    endfunction

    task automatic cycle(input logic op, input logic rv, input logic [RT-1:0] w,
                         input logic fl, input logic rst);
        logic [RT-1:0] hd, sw;
        logic          exp_opr, exp_rdy, adm;
        logic [R1-1:0] exp_s1;
        int            lvl, due;
        in_reset = rst; in_op_valid = op; in_rand_valid = rv; in_rand = w; in_flush = fl;
        lvl     = mf.size();
        hd      = (lvl > 0) ? mf[0] : '0;
        exp_opr = (lvl > 0) && !fl;
        adm     = op && exp_opr;
        exp_rdy = (lvl < DEPTH) || adm;
        @(negedge in_clock);
        obs_rdy = out_rand_ready; obs_opr = out_op_ready; obs_res = out_result_valid;
        obs_en = out_stage_en; obs_level = out_fifo_level;
        obs_s1 = out_random_s1; obs_s2 = out_random_s2; obs_s3 = out_random_s3;
`ifdef MASKED_RAND_SCHED_CNT_EN
        obs_stc = out_starve_count;
`else
        obs_stc = '0;
`endif
        if (obs_res === 1'b1) res_seen++;
        if (!rst) begin
            tests++; if (obs_rdy !== exp_rdy) begin fails++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", cyc, obs_rdy, exp_rdy); end
            tests++; if (obs_opr !== exp_opr) begin fails++; $display("FAIL op_ready cyc=%0d got=%b exp=%b", cyc, obs_opr, exp_opr); end
            tests++; if (obs_level !== LW'(lvl)) begin fails++; $display("FAIL level cyc=%0d got=%0d exp=%0d", cyc, obs_level, lvl); end
            tests++; if (obs_en !== {v2m, v1m, adm}) begin fails++; $display("FAIL stage_en cyc=%0d got=%b exp=%b", cyc, obs_en, {v2m, v1m, adm}); end
            exp_s1  = adm ? hd[R1-1:0] : last_s1;
            last_s1 = exp_s1;
            tests++; if (obs_s1 !== exp_s1) begin fails++; $display("FAIL random_s1 cyc=%0d got=%h exp=%h", cyc, obs_s1, exp_s1); end
            if (v1m && s2q.size() > 0) begin
                sw = s2q.pop_front(); last_s2 = sw[R1+R2-1:R1]; s3q.push_back(sw);
            end
            if (v2m && s3q.size() > 0) begin
                sw = s3q.pop_front(); last_s3 = sw[RT-1:R1+R2];
            end
            tests++; if (obs_s2 !== last_s2) begin fails++; $display("FAIL random_s2 cyc=%0d got=%h exp=%h", cyc, obs_s2, last_s2); end
            tests++; if (obs_s3 !== last_s3) begin fails++; $display("FAIL random_s3 cyc=%0d got=%h exp=%h", cyc, obs_s3, last_s3); end
            tests++;
            if (obs_res !== 1'b0) begin
                if (resq.size() == 0) begin
                    fails++; $display("FAIL result_unexpected cyc=%0d got=%b exp=0", cyc, obs_res);
                end else begin
                    due = resq.pop_front();
                    if (due != cyc) begin fails++; $display("FAIL result_time got=%0d exp=%0d", cyc, due); end
                end
            end else if (resq.size() > 0 && resq[0] == cyc) begin
                fails++; $display("FAIL result_missing cyc=%0d got=0 exp=1", cyc);
                void'(resq.pop_front());
            end
`ifdef MASKED_RAND_SCHED_CNT_EN
            tests++; if (out_op_count !== 32'(opc)) begin fails++; $display("FAIL op_count cyc=%0d got=%0d exp=%0d", cyc, out_op_count, opc); end
            tests++; if (out_starve_count !== 32'(stc)) begin fails++; $display("FAIL starve_count cyc=%0d got=%0d exp=%0d", cyc, out_starve_count, stc); end
`endif
        end
        @(posedge in_clock); #1;
        if (rst) begin
            mf.delete(); s2q.delete(); s3q.delete(); resq.delete();
            v1m = 1'b0; v2m = 1'b0; last_s1 = '0; last_s2 = '0; last_s3 = '0;
            opc = 0; stc = 0;
        end else begin
            v2m = v1m; v1m = adm;
            if (adm) begin s2q.push_back(hd); resq.push_back(cyc + 3); end
            if (fl) begin
                mf.delete(); opc = 0; stc = 0;
            end else begin
                if (adm) void'(mf.pop_front());
                if (rv && exp_rdy) mf.push_back(w);
                if (adm) opc++;
                if (op && !exp_opr) stc++;
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic write_words(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, rnd_word(), 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
        idle(1);
        tests++; if (obs_rdy !== 1'b1) begin fails++; $display("FAIL reset_rand_ready got=%b exp=1", obs_rdy); end
        tests++; if (obs_level !== '0) begin fails++; $display("FAIL reset_level got=%0d exp=0", obs_level); end
        tests++; if ({obs_en, obs_res} !== 4'b0) begin fails++; $display("FAIL reset_en_res got=%b exp=0000", {obs_en, obs_res}); end
        tests++; if ({obs_s1, obs_s2, obs_s3} !== '0) begin fails++; $display("FAIL reset_randoms got=%h exp=0", {obs_s1, obs_s2, obs_s3}); end
    endtask

    task automatic test_basic();
        logic [2:0]    exp_en [6];
        logic          exp_res[6];
        logic [RT-1:0] w0;
        exp_en  = '{3'b001, 3'b011, 3'b111, 3'b110, 3'b100, 3'b000};
        exp_res = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        w0 = rnd_word();
        cycle(1'b0, 1'b1, w0, 1'b0, 1'b0);
        write_words(2);
        for (int i = 0; i < 6; i++) begin
            cycle(i < 3, 1'b0, '0, 1'b0, 1'b0);
            tests++; if (obs_en !== exp_en[i]) begin fails++; $display("FAIL basic_en i=%0d got=%b exp=%b", i, obs_en, exp_en[i]); end
            tests++; if (obs_res !== exp_res[i]) begin fails++; $display("FAIL basic_res i=%0d got=%b exp=%b", i, obs_res, exp_res[i]); end
            if (i == 1) begin
                tests++; if (obs_s2 !== w0[R1+R2-1:R1]) begin fails++; $display("FAIL basic_s2 got=%h exp=%h", obs_s2, w0[R1+R2-1:R1]); end
            end
            if (i == 2) begin
                tests++; if (obs_s3 !== w0[RT-1:R1+R2]) begin fails++; $display("FAIL basic_s3 got=%h exp=%h", obs_s3, w0[RT-1:R1+R2]); end
            end
        end
    endtask

    task automatic test_full();
        write_words(4);
        cycle(1'b0, 1'b1, rnd_word(), 1'b0, 1'b0);
        tests++; if (obs_rdy !== 1'b0) begin fails++; $display("FAIL full_ready got=%b exp=0", obs_rdy); end
        cycle(1'b1, 1'b1, rnd_word(), 1'b0, 1'b0);
        tests++; if (obs_rdy !== 1'b1) begin fails++; $display("FAIL full_wr_pop_ready got=%b exp=1", obs_rdy); end
        idle(1);
        tests++; if (obs_level !== LW'(4)) begin fails++; $display("FAIL full_wr_pop_level got=%0d exp=4", obs_level); end
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
        idle(3);
    endtask

    task automatic test_starve();
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
            tests++; if (obs_opr !== 1'b0) begin fails++; $display("FAIL starve_op_ready i=%0d got=%b exp=0", i, obs_opr); end
        end
        cycle(1'b1, 1'b1, rnd_word(), 1'b0, 1'b0);
        tests++; if (obs_opr !== 1'b0) begin fails++; $display("FAIL starve_no_bypass got=%b exp=0", obs_opr); end
`ifdef MASKED_RAND_SCHED_CNT_EN
        tests++; if (obs_stc !== 32'd5) begin fails++; $display("FAIL starve_count5 got=%0d exp=5", obs_stc); end
`endif
        cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
        tests++; if ({obs_opr, obs_en[0]} !== 2'b11) begin fails++; $display("FAIL starve_admit got=%b exp=11", {obs_opr, obs_en[0]}); end
        idle(3);
    endtask

    task automatic test_flush();
        int base;
        write_words(4);
        cycle(1'b1, 1'b1, rnd_word(), 1'b0, 1'b0);
        cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
        base = res_seen;
        cycle(1'b1, 1'b1, rnd_word(), 1'b1, 1'b0);
        tests++; if (obs_opr !== 1'b0) begin fails++; $display("FAIL flush_blocks_admit got=%b exp=0", obs_opr); end
        idle(1);
        tests++; if (obs_level !== '0) begin fails++; $display("FAIL flush_level got=%0d exp=0", obs_level); end
        idle(3);
        tests++; if (res_seen - base !== 2) begin fails++; $display("FAIL flush_inflight_results got=%0d exp=2", res_seen - base); end
    endtask

    task automatic test_reset_mid();
        write_words(2);
        cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            idle(1);
            tests++; if ({obs_res, obs_en, obs_level} !== '0) begin fails++; $display("FAIL reset_mid i=%0d got=%b exp=0", i, {obs_res, obs_en, obs_level}); end
        end
    endtask

    task automatic test_bubble();
        logic [RT-1:0] w0;
        w0 = rnd_word() | RT'(1) | (RT'(1) << R1) | (RT'(1) << (R1 + R2));
        cycle(1'b0, 1'b1, w0, 1'b0, 1'b0);
        write_words(2);
        cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
        tests++; if (obs_en !== 3'b010 || obs_s1 !== w0[R1-1:0]) begin fails++; $display("FAIL bubble_s1_hold en=%b got=%h exp=%h", obs_en, obs_s1, w0[R1-1:0]); end
        cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
        tests++; if (obs_en !== 3'b101 || obs_s2 !== w0[R1+R2-1:R1]) begin fails++; $display("FAIL bubble_s2_hold en=%b got=%h exp=%h", obs_en, obs_s2, w0[R1+R2-1:R1]); end
        cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
        tests++; if (obs_en !== 3'b011 || obs_s3 !== w0[RT-1:R1+R2]) begin fails++; $display("FAIL bubble_s3_hold en=%b got=%h exp=%h", obs_en, obs_s3, w0[RT-1:R1+R2]); end
        idle(4);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 40; i++)
            cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), rnd_word(), 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
        idle(3);
        tests++; if (obs_level !== '0 || obs_en !== 3'b000) begin fails++; $display("FAIL b2b_drain level=%0d en=%b exp=0/000", obs_level, obs_en); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_starve();
        test_flush();
        test_reset_mid();
        test_bubble();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/masked_3stage_rand_sched.md
# masked_3stage_rand_sched

Randomness scheduler for the three-stage masked HPC3 GF(2^8) inverter. Accepts fresh random words from an external TRNG/PRNG through a valid/ready port and buffers them in a small FIFO. Admits S-box operations only when a full random word is available, then delivers each stage's random slice exactly in the cycle that stage consumes it. Sits between the randomness source and the S-box pipeline, and drives the per-stage enables.

## Interface
Parameters:
- NUM_SHARES, 2, number of Boolean shares.
- FIFO_DEPTH, 4, random-word buffer depth; power of two, at least 2.
- R1 / R2 / R3, stage_1/2/3_hpc3_randoms(NUM_SHARES), per-stage random bits (localparams).
- RAND_TOTAL, R1+R2+R3, width of one random word (localparam).

Ports:
- in_clock  input  1  clock; all state updates on the rising edge.
- in_reset  input  1  synchronous, active-high reset.
- in_rand  input  RAND_TOTAL  random word, slice order {s3, s2, s1}, s1 in the LSBs.
- in_rand_valid  input  1  random word offered.
- out_rand_ready  output  1  FIFO not full.
- in_flush  input  1  discard all buffered random words.
- in_op_valid  input  1  S-box operation requested this cycle.
- out_op_ready  output  1  operation admitted when high and in_op_valid is high.
- out_stage_en  output  3  bit k = stage k+1 register enable this cycle.
- out_random_s1 / s2 / s3  output  R1 / R2 / R3  random slices to stages 1–3.
- out_result_valid  output  1  stage-3 output valid.
- out_fifo_level  output  $clog2(FIFO_DEPTH)+1  buffered word count.

## Operation
- FIFO write when in_rand_valid && out_rand_ready. Read (pop) on an admitted op.
- out_op_ready = FIFO non-empty && !in_flush. Combinational; does not depend on in_op_valid.
- Admission at cycle t: pop the head word.
  - Its s1 slice is driven combinationally from the FIFO head in cycle t.
  - Its s2 and s3 slices are registered into a slice pipeline.
- Valid pipeline v[2:0]:
  - v[0] = admit.
  - v[1] and v[2] are shifted registers.
  - out_stage_en = v.
  - out_result_valid = registered v[2], i.e. at t+3.
- The pipeline never stalls; bubbles flow with enable low.
- While a stage's enable is low, its random output holds its previous value. Zero is never substituted.
- out_random_s2 = s2 of the word admitted at t-1. out_random_s3 = s3 of the word admitted at t-2.
- Each random word is used by exactly one operation; a word is never reused.
- Simultaneous write and pop:
  - Allowed when the FIFO is full; level unchanged.
  - When the FIFO is empty, the incoming word is not bypassed. out_op_ready stays low that cycle.
- in_flush:
  - Clears the FIFO pointers and level at the edge.
  - Blocks admission that cycle.
  - A write in the same cycle is dropped, even if out_rand_ready is high.
  - Operations already in flight complete normally with their own slices.
- Pointers wrap modulo FIFO_DEPTH. Level is 0..FIFO_DEPTH.

## Timing
- Latency: admission at t gives stage enables at t, t+1, t+2 and out_result_valid at t+3.
- Throughput: one op per cycle while the FIFO stays non-empty.
- out_rand_ready falls in the cycle after the FIFO becomes full.
- Reset values: all output registers are 0, the FIFO is empty, and out_rand_ready = 1 from the first post-reset cycle.
- Reset mid-operation: all in-flight valid bits are cleared and the results are dropped. No out_result_valid is asserted for them.

## Configuration
- MASKED_RAND_SCHED_CNT_EN. When defined, two extra outputs are added:
  - out_op_count (32 bits): counts admitted ops.
  - out_starve_count (32 bits): counts cycles with in_op_valid && !out_op_ready.
  - Both counters saturate at all-ones and are cleared by reset and by in_flush.
- Undefined: the ports and registers are absent; all other behaviour is identical.

## Structure
- aes128_package holds:
  - stage_1_hpc3_randoms and stage_3_hpc3_randoms, alongside the existing stage_2_hpc3_randoms.
  - the rand_total(NUM_SHARES) function.
- Sub-module masked_rand_fifo: a generic synchronous FIFO parameterised on WIDTH and DEPTH. It exposes a level output and a flush input.
- Slice pipeline, valid pipeline and counters live in the top module.

## Test plan
- Reset, then offer 3 words W0..W2 and request ops on 3 consecutive cycles. Check:
  - out_stage_en = 001, 011, 111, 110, 100.
  - out_result_valid at cycles 3–5.
  - out_random_s2 = W0[s2] in cycle 1; out_random_s3 = W0[s3] in cycle 2.
- Fill the FIFO to 4 with no op requests. Check out_rand_ready = 0 and a fifth offered word is not accepted. Then write and pop in the same cycle: level stays 4.
- FIFO empty with in_op_valid held for 5 cycles. Check out_op_ready = 0 throughout and, with the macro defined, out_starve_count = 5. Write one word: the op is admitted exactly one cycle later.
- Admit 2 ops, then assert in_flush with 3 words buffered. Check:
  - level is 0 next cycle.
  - both in-flight ops still produce out_result_valid.
  - a write in the flush cycle is dropped.
- Assert in_reset in the cycle after admission. Check no out_result_valid, all enables 0, and level 0.
- Drive admits around a bubble. Check the bubble's stage random outputs hold their last values (no zeroing) while the matching enable is low.
